// File: rtl/paper_pkg.sv
// Shared opcode constants and loader state encoding for the program writer slice.
package paper_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_JNO = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FILL   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } pw_state_t;

endpackage

// File: rtl/program_writer_if.sv
// Bundles the host-side stream, RAM port and status lines of the program writer.
// The host (or bench) uses the master modport; the loader uses the slave modport.
interface program_writer_if #(
    parameter int ADDR_W  = 2,
    parameter int INSTR_W = 2
);

    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               in_last;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic [INSTR_W-1:0] mem_rdata;
    logic               cpu_hold;
    logic               load_done;
    logic               load_err;
    logic               overflow;

    modport master (
        output start, in_valid, in_instr, in_last, mem_rdata,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, load_done, load_err, overflow
    );

    modport slave (
        input  start, in_valid, in_instr, in_last, mem_rdata,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, load_done, load_err, overflow
    );

endinterface

// File: rtl/pw_addr_counter.sv
// RAM address counter shared by the load/fill and read-back phases.
// Saturates at DEPTH-1; only a clear brings it back to zero.
module pw_addr_counter #(
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_count;

    assign o_tc    = (r_count == ADDR_W'(DEPTH - 1));
    assign o_count = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_tc) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/program_writer.sv
// Streams a program image into the instruction RAM, pads the tail with HLT and holds the CPU until done.
// Define PROGRAM_WRITER_VERIFY_EN to add the shadow copy and read-back VERIFY pass.
module program_writer
    import paper_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    program_writer_if.slave bus
);

`ifdef PROGRAM_WRITER_VERIFY_EN
    localparam pw_state_t ST_AFTER_WRITE = ST_VERIFY;
`else
    localparam pw_state_t ST_AFTER_WRITE = ST_DONE;
`endif

    pw_state_t          r_state;
    pw_state_t          w_next_state;
    logic               w_handshake;
    logic               w_wr_en;
    logic [INSTR_W-1:0] w_wr_data;
    logic               w_cnt_clear;
    logic               w_cnt_inc;
    logic               w_restart;
    logic [ADDR_W-1:0]  w_cnt;
    logic               w_cnt_tc;

    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [INSTR_W-1:0] r_mem_wdata;
    logic               r_overflow;

`ifdef PROGRAM_WRITER_VERIFY_EN
    logic [INSTR_W-1:0] r_shadow [DEPTH];
    logic               r_rd_valid;
    logic               w_rd_issue;
`else
    logic               w_unused_rdata;
    assign w_unused_rdata = ^bus.mem_rdata;
`endif

    pw_addr_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (w_cnt_clear),
        .i_inc   (w_cnt_inc),
        .o_count (w_cnt),
        .o_tc    (w_cnt_tc)
    );

    assign w_handshake = bus.in_valid && (r_state == ST_LOAD);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_data    = bus.in_instr;
        w_cnt_clear  = 1'b0;
        w_cnt_inc    = 1'b0;
        w_restart    = 1'b0;
`ifdef PROGRAM_WRITER_VERIFY_EN
        w_rd_issue   = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_ERROR, ST_DONE: begin
                if (bus.start) begin
                    w_next_state = ST_LOAD;
                    w_cnt_clear  = 1'b1;
                    w_restart    = 1'b1;
                end
            end
            ST_LOAD: begin
                // The top address ends the load regardless of in_last, so the counter never wraps.
                if (w_handshake) begin
                    w_wr_en = 1'b1;
                    if (w_cnt_tc) begin
                        w_next_state = ST_AFTER_WRITE;
                        w_cnt_clear  = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                        if (bus.in_last) begin
                            w_next_state = ST_FILL;
                        end
                    end
                end
            end
            ST_FILL: begin
                w_wr_en   = 1'b1;
                w_wr_data = INSTR_W'(OP_HLT);
                if (w_cnt_tc) begin
                    w_next_state = ST_AFTER_WRITE;
                    w_cnt_clear  = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
`ifdef PROGRAM_WRITER_VERIFY_EN
            ST_VERIFY: begin
                // First VERIFY cycle still carries the final write strobe, so reads trail by one cycle.
                w_rd_issue = 1'b1;
                w_cnt_inc  = 1'b1;
                if (r_rd_valid) begin
                    if (bus.mem_rdata != r_shadow[r_mem_addr]) begin
                        w_next_state = ST_ERROR;
                    end else if (r_mem_addr == ADDR_W'(DEPTH - 1)) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_mem_we <= w_wr_en;
            if (w_wr_en) begin
                r_mem_addr  <= w_cnt;
                r_mem_wdata <= w_wr_data;
`ifdef PROGRAM_WRITER_VERIFY_EN
            end else if (w_rd_issue) begin
                r_mem_addr <= w_cnt;
`endif
            end
            if (w_restart) begin
                r_overflow <= 1'b0;
            end else if ((r_state == ST_DONE) && bus.in_valid) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef PROGRAM_WRITER_VERIFY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[i] <= '0;
            end
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_shadow[w_cnt] <= w_wr_data;
            end
            r_rd_valid <= w_rd_issue;
        end
    end

    assign bus.load_err = (r_state == ST_ERROR);
`else
    assign bus.load_err = 1'b0;
`endif

    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.cpu_hold  = (r_state != ST_DONE);
    assign bus.load_done = (r_state == ST_DONE);
    assign bus.overflow  = r_overflow;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_program_writer.sv
// Scoreboard bench for program_writer: stimulus queues the expected RAM image, a monitor checks each write.
module tb_program_writer;
    import paper_pkg::*;

    localparam int ADDR_W  = 2;
    localparam int DEPTH   = 4;
    localparam int INSTR_W = 2;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
        bit                 mustFollow;
    } wr_t;

    logic clock = 1'b0;
    logic reset_n;

    program_writer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    program_writer #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    wr_t                expQ[$];
    int                 checkCount  = 0;
    int                 passCount   = 0;
    int                 cycle       = 0;
    int                 lastWrCycle = -10;
    logic               prevDone    = 1'b0;
    bit                 corruptEn   = 1'b0;
    logic [INSTR_W-1:0] ram [DEPTH];
    logic [INSTR_W-1:0] imageWords [DEPTH];

    // Behavioural RAM; the corrupt hook fakes a bad cell at address 2 for the read-back path.
    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (bus.mem_we === 1'b1) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = (corruptEn && (bus.mem_addr == 2'd2)) ? OP_INC : ram[bus.mem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Every RAM write must match the head of the expected queue; done may only rise once it drains.
    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousWe", 32'(bus.mem_we), 32'd0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("wrAddr", 32'(bus.mem_addr), 32'(e.addr));
                checkOutput("wrData", 32'(bus.mem_wdata), 32'(e.data));
                if (e.mustFollow) begin
                    checkOutput("wrBackToBack", 32'(cycle - lastWrCycle), 32'd1);
                end
            end
            lastWrCycle = cycle;
        end
        if ((bus.load_done === 1'b1) && (prevDone !== 1'b1)) begin
            checkOutput("doneQueueEmpty", 32'(expQ.size()), 32'd0);
            checkOutput("doneCpuHold", 32'(bus.cpu_hold), 32'd0);
        end
        prevDone = bus.load_done;
    end

    task automatic pulseStart();
        @(posedge clock);
        #1 bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
    endtask

    // gapMode: 0 = back-to-back words, 1 = one idle cycle before every word, 2 = random idles.
    task automatic applyStimulus(input int len, input bit lastOnFinal, input int gapMode, input bit expectErr);
        logic accepted;
        logic finished;
        for (int a = 0; a < DEPTH; a++) begin
            wr_t e;
            e.addr       = ADDR_W'(a);
            e.data       = (a < len) ? imageWords[a] : OP_HLT;
            e.mustFollow = (a > 0) && ((a >= len) || (gapMode == 0));
            expQ.push_back(e);
        end
        pulseStart();
        checkOutput("startCpuHold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("startOvfClear", 32'(bus.overflow), 32'd0);
        checkOutput("startDoneLow", 32'(bus.load_done), 32'd0);
        for (int i = 0; i < len; i++) begin
            if (gapMode == 1) begin
                bus.in_valid = 1'b0;
                @(posedge clock);
                #1;
            end else if (gapMode == 2) begin
                while ($urandom_range(99) < 40) begin
                    bus.in_valid = 1'b0;
                    @(posedge clock);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_instr = imageWords[i];
            bus.in_last  = (i == len - 1) && ((len < DEPTH) || lastOnFinal);
            accepted = 1'b0;
            for (int t = 0; (t < 20) && !accepted; t++) begin
                @(negedge clock);
                accepted = bus.in_ready;
                @(posedge clock);
                #1;
            end
            if (accepted !== 1'b1) begin
                checkOutput("readyTimeout", 32'(accepted), 32'd1);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        finished = 1'b0;
        for (int t = 0; (t < 40) && !finished; t++) begin
            @(negedge clock);
            #1;
            finished = bus.load_done || bus.load_err;
        end
        checkOutput("loadFinished", 32'(finished), 32'd1);
        checkOutput("loadErr", 32'(bus.load_err), 32'(expectErr));
        checkOutput("cpuHoldEnd", 32'(bus.cpu_hold), 32'(expectErr));
        checkOutput("inReadyEnd", 32'(bus.in_ready), 32'd0);
        if (finished !== 1'b1) begin
            expQ.delete();
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_last  = 1'b0;
        #7;
        checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
        checkOutput("rstMemWe", 32'(bus.mem_we), 32'd0);
        checkOutput("rstMemAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rstMemWdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("rstCpuHold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("rstLoadDone", 32'(bus.load_done), 32'd0);
        checkOutput("rstLoadErr", 32'(bus.load_err), 32'd0);
        checkOutput("rstOverflow", 32'(bus.overflow), 32'd0);
        #5 reset_n = 1'b1;

        imageWords = '{OP_INC, OP_INC, OP_JNO, OP_HLT};
        applyStimulus(4, 1'b1, 0, 1'b0);

        imageWords[0] = OP_INC;
        applyStimulus(1, 1'b1, 0, 1'b0);

        // Words offered while DONE must be refused and flagged, and only start clears the flag.
        @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        bus.in_instr = OP_JNO;
        repeat (3) begin
            @(negedge clock);
            checkOutput("ovfInReady", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(negedge clock);
        checkOutput("ovfSet", 32'(bus.overflow), 32'd1);
        repeat (3) @(negedge clock);
        checkOutput("ovfSticky", 32'(bus.overflow), 32'd1);
        checkOutput("ovfDoneHeld", 32'(bus.load_done), 32'd1);

        imageWords = '{OP_JNO, OP_NOP, OP_INC, OP_JNO};
        applyStimulus(4, 1'b0, 1, 1'b0);

        expQ.push_back('{2'd0, OP_INC, 1'b0});
        expQ.push_back('{2'd1, OP_JNO, 1'b1});
        pulseStart();
        bus.in_valid = 1'b1;
        bus.in_instr = OP_INC;
        bus.in_last  = 1'b0;
        @(posedge clock);
        #1 bus.in_instr = OP_JNO;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midRstCpuHold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("midRstMemWe", 32'(bus.mem_we), 32'd0);
        checkOutput("midRstMemAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("midRstInReady", 32'(bus.in_ready), 32'd0);
        checkOutput("midRstWrites", 32'(expQ.size()), 32'd0);
        expQ.delete();
        #3 reset_n = 1'b1;

        repeat (12) begin
            int len;
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                imageWords[i] = INSTR_W'($urandom_range(0, 3));
            end
            applyStimulus(len, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
        end

`ifdef PROGRAM_WRITER_VERIFY_EN
        corruptEn  = 1'b1;
        imageWords = '{OP_INC, OP_INC, OP_JNO, OP_HLT};
        applyStimulus(4, 1'b1, 0, 1'b1);
        corruptEn  = 1'b0;
        applyStimulus(2, 1'b1, 0, 1'b0);
`endif

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
